aes_inv_mixcol_seq: RTL and testbench
=====================================

AES_INV_MIXCOL_SEQ -- requirements
Module: aes_inv_mixcol_seq

Interface
REQ-001 SHALL provide parameter COLS_PER_CYCLE, default 1, giving the number of state columns transformed per clock; legal values are 1, 2 and 4.
REQ-002 SHALL provide port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL provide port in_valid, input, 1 bit, upstream has a state word on in_data.
REQ-005 SHALL provide port in_ready, output, 1 bit, block can accept a state word this cycle.
REQ-006 SHALL provide port in_data, input, 128 bits: byte s0 is in_data[127:120] and s15 is in_data[7:0]; column c is bytes s(4c)..s(4c+3).
REQ-007 SHALL provide port in_bypass, input, 1 bit, sampled with in_data; 1 = pass state unchanged (final decryption round).
REQ-008 SHALL provide port out_valid, output, 1 bit, out_data holds a completed result.
REQ-009 SHALL provide port out_ready, input, 1 bit, downstream accepts the result this cycle.
REQ-010 SHALL provide port out_data, output, 128 bits, with the same byte ordering as in_data.
REQ-011 SHALL provide port busy, output, 1 bit, high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and HOLD.
REQ-013 SHALL drive in_ready = 1 only in IDLE.
REQ-014 SHALL, on an accept edge (in_valid & in_ready), capture in_data into a 128-bit state register, capture in_bypass, clear column counter col_idx to 0, and go to BUSY.
REQ-015 SHALL, on each BUSY edge, replace columns col_idx..col_idx+COLS_PER_CYCLE-1 of the state register with their InvMixColumns result and advance col_idx by COLS_PER_CYCLE.
REQ-016 SHALL compute InvMixColumns per column (a0..a3) as b0=0e·a0^0b·a1^0d·a2^09·a3, b1=09·a0^0e·a1^0b·a2^0d·a3, b2=0d·a0^09·a1^0e·a2^0b·a3, b3=0b·a0^0d·a1^09·a2^0e·a3.
REQ-017 SHALL perform all products in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B), built from xtime chains with no lookup tables.
REQ-018 SHALL leave the column unchanged when the captured bypass is 1, while still spending the same number of BUSY cycles.
REQ-019 SHALL go from BUSY to HOLD on the edge that processes the last column.
- Accept-to-out_valid latency is exactly 4/COLS_PER_CYCLE+1 edges (5, 3 or 2).
REQ-020 SHALL assert out_valid only in HOLD, with out_data equal to the state register.
REQ-021 SHALL keep out_data and out_valid stable in HOLD until out_ready = 1.
REQ-022 SHALL go from HOLD to IDLE on out_valid & out_ready.
- in_ready rises in the following cycle.
- Minimum spacing between accepts is 4/COLS_PER_CYCLE+2 cycles.
REQ-023 SHALL ignore in_valid and in_data outside IDLE; no input is dropped silently, because in_ready = 0 there.
REQ-024 SHALL treat col_idx as a 2-bit counter that wraps to 0 after column 3 and is never used outside BUSY.
REQ-025 SHALL hold out_data constant outside HOLD; its value there is don't-care to consumers and is never X after reset.

Reset
REQ-026 SHALL, when rst = 1 at a clock edge, force IDLE, col_idx = 0, captured bypass = 0 and state register = 0.
- Resulting outputs: in_ready = 1, out_valid = 0, busy = 0, out_data = 0.
REQ-027 SHALL give rst priority over every handshake.
- Reset in BUSY or HOLD discards the in-flight word.
- in_valid during a reset cycle is not accepted.
REQ-028 SHALL require no reset on any other storage for correct function.

Verification
REQ-029 SHALL pass a FIPS-197 vector: COLS_PER_CYCLE=1, bypass=0, in_data=8e4da1bc_9fdc589d_01010101_d5d5d7d6.
- Required: out_data=db135345_f20a225c_01010101_d4d4d4d5.
- out_valid rises exactly 5 edges after the accept.
REQ-030 SHALL pass a bypass test: bypass=1 with in_data=4d7ebdf8_00000000_c6c6c6c6_ffffffff.
- Required: identical out_data, and the same latency as REQ-029.
REQ-031 SHALL pass a backpressure test: out_ready held 0 for 10 cycles in HOLD.
- Required: out_data and out_valid stable throughout and in_ready = 0.
- When out_ready = 1, IDLE is reached on that edge and in_ready = 1 in the next cycle.
REQ-032 SHALL pass a mid-operation reset test: rst pulsed 1 cycle at the second BUSY cycle.
- Required next cycle: in_ready=1, out_valid=0, out_data=0.
- A following vector 4d7ebdf8 in column 0 yields 2d26314c.
REQ-033 SHALL pass a parameter sweep over COLS_PER_CYCLE=2 and 4 with the REQ-029 vector.
- Required: same out_data, with latency 3 and 2 respectively.
REQ-034 SHALL pass a random test of 1000 vectors with random valid/ready against an InvMixColumns reference model.
- Required: every result matches the model and no accepted word is lost or duplicated.

Source files
------------

// File: rtl/aes_inv_mixcol_seq_if.sv
// Handshake bundle for the sequential AES InvMixColumns engine:
// upstream state word in, transformed state word out, plus a busy flag.
interface aes_inv_mixcol_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport slave (
        input  in_valid, in_data, in_bypass, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_bypass, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_inv_mixcol_seq.sv
// Sequential AES InvMixColumns: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock, then holds the result until taken.
module aes_inv_mixcol_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    aes_inv_mixcol_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

    // Column step truncated to 2 bits: with four columns per cycle it wraps to 0.
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

    state_t       state_q, state_d;
    logic [1:0]   col_idx_q;
    logic         bypass_q;
    logic [127:0] st_q;
    logic [127:0] st_next;
    logic [127:0] out_q;
    logic [1:0]   rel;
    logic         accept;
    logic         last_col;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m2 [4];
        logic [7:0] m4 [4];
        logic [7:0] m8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            m2[i] = xtime(a[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
            m9[i] = m8[i] ^ a[i];
            mb[i] = m8[i] ^ m2[i] ^ a[i];
            md[i] = m8[i] ^ m4[i] ^ a[i];
            me[i] = m8[i] ^ m4[i] ^ m2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_data  = out_q;

    assign accept   = bus.in_valid & (state_q == IDLE);
    assign last_col = (int'(col_idx_q) + COLS_PER_CYCLE >= 4);

    // A column is rewritten when it lies in the window starting at col_idx.
    always_comb begin
        st_next = st_q;
        rel     = 2'd0;
        for (int c = 0; c < 4; c++) begin
            rel = 2'(c) - col_idx_q;
            if (!bypass_q && (int'(rel) < COLS_PER_CYCLE)) begin
                st_next[127-32*c -: 32] = inv_mix_col(st_q[127-32*c -: 32]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (last_col) state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // out_q is loaded only when the last column completes, so the output
    // never shows partially transformed state.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_idx_q <= 2'd0;
            bypass_q  <= 1'b0;
            st_q      <= '0;
            out_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        st_q      <= bus.in_data;
                        bypass_q  <= bus.in_bypass;
                        col_idx_q <= 2'd0;
                    end
                end
                BUSY: begin
                    st_q      <= st_next;
                    col_idx_q <= col_idx_q + STEP;
                    if (last_col) out_q <= st_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_mixcol_seq.sv
// Scoreboard bench for aes_inv_mixcol_seq: directed FIPS-197, bypass,
// backpressure, reset and parameter cases, then a randomized handshake run.
module tb_aes_inv_mixcol_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes_inv_mixcol_seq_if bus1 ();
    aes_inv_mixcol_seq_if bus2 ();
    aes_inv_mixcol_seq_if bus4 ();

    aes_inv_mixcol_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    aes_inv_mixcol_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    aes_inv_mixcol_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] BYP_IN   = 128'h4d7ebdf8_00000000_c6c6c6c6_ffffffff;
    localparam logic [127:0] BYP_INV  = 128'h2d26314c_00000000_c6c6c6c6_ffffffff;

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] exp_q [$];

    // Reference: plain shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic byp);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = s;
        if (!byp) begin
            for (int c = 0; c < 4; c++) begin
                a0 = s[127-32*c -: 8];
                a1 = s[119-32*c -: 8];
                a2 = s[111-32*c -: 8];
                a3 = s[103-32*c -: 8];
                r[127-32*c -: 32] = {
                    gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3),
                    gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3),
                    gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3),
                    gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3)};
            end
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus1.in_valid = 1'b1; bus1.in_data = FIPS_IN; bus1.in_bypass = 1'b0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_bypass = 1'b0; bus2.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_bypass = 1'b0; bus4.out_ready = 1'b0;
        tick; tick;
        n_vec++; if (bus1.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus1.in_ready); end
        n_vec++; if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus1.out_valid); end
        n_vec++; if (bus1.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus1.busy); end
        n_vec++; if (bus1.out_data !== 128'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", bus1.out_data); end
        rst = 1'b0;
        bus1.in_valid = 1'b0;
        tick;
        n_vec++; if (bus1.busy !== 1'b0) begin n_err++; $display("FAIL reset_no_accept busy got %b want 0", bus1.busy); end
    endtask

    task automatic test_fips;
        int lat;
        exp_q.push_back(model(FIPS_IN, 1'b0));
        bus1.in_data = FIPS_IN; bus1.in_bypass = 1'b0; bus1.in_valid = 1'b1;
        tick;
        bus1.in_valid = 1'b0; bus1.in_data = '0;
        lat = 1;
        n_vec++; if (bus1.in_ready !== 1'b0) begin n_err++; $display("FAIL fips_in_ready_busy got %b want 0", bus1.in_ready); end
        while (bus1.out_valid !== 1'b1 && lat < 20) begin tick; lat++; end
        n_vec++; if (lat != 5) begin n_err++; $display("FAIL fips_latency got %0d want 5", lat); end
        n_vec++; if (bus1.out_data !== FIPS_OUT) begin n_err++; $display("FAIL fips_data got %h want %h", bus1.out_data, FIPS_OUT); end
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL fips_scoreboard got empty want 1 entry"); end
        else if (bus1.out_data !== exp_q[0]) begin n_err++; $display("FAIL fips_model got %h want %h", bus1.out_data, exp_q[0]); void'(exp_q.pop_front()); end
        else void'(exp_q.pop_front());
        bus1.out_ready = 1'b1;
        tick;
        bus1.out_ready = 1'b0;
        n_vec++; if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL fips_release_out_valid got %b want 0", bus1.out_valid); end
        n_vec++; if (bus1.in_ready !== 1'b1) begin n_err++; $display("FAIL fips_release_in_ready got %b want 1", bus1.in_ready); end
    endtask

    task automatic test_bypass;
        int lat;
        exp_q.push_back(model(BYP_IN, 1'b1));
        bus1.in_data = BYP_IN; bus1.in_bypass = 1'b1; bus1.in_valid = 1'b1;
        tick;
        bus1.in_valid = 1'b0; bus1.in_bypass = 1'b0; bus1.in_data = '0;
        lat = 1;
        while (bus1.out_valid !== 1'b1 && lat < 20) begin tick; lat++; end
        n_vec++; if (lat != 5) begin n_err++; $display("FAIL bypass_latency got %0d want 5", lat); end
        n_vec++; if (bus1.out_data !== BYP_IN) begin n_err++; $display("FAIL bypass_data got %h want %h", bus1.out_data, BYP_IN); end
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL bypass_scoreboard got empty want 1 entry"); end
        else if (bus1.out_data !== exp_q.pop_front()) begin n_err++; $display("FAIL bypass_model got %h", bus1.out_data); end
        bus1.out_ready = 1'b1;
        tick;
        bus1.out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int lat;
        logic [127:0] e;
        e = model(FIPS_IN, 1'b0);
        exp_q.push_back(e);
        bus1.in_data = FIPS_IN; bus1.in_bypass = 1'b0; bus1.in_valid = 1'b1;
        tick;
        bus1.in_data = BYP_IN;
        lat = 1;
        while (bus1.out_valid !== 1'b1 && lat < 20) begin tick; lat++; end
        n_vec++; if (lat != 5) begin n_err++; $display("FAIL bp_latency got %0d want 5", lat); end
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (bus1.out_valid !== 1'b1 || bus1.in_ready !== 1'b0 || bus1.out_data !== e) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d got valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                         i, bus1.out_valid, bus1.in_ready, bus1.out_data, e);
            end
            tick;
        end
        bus1.out_ready = 1'b1;
        tick;
        bus1.out_ready = 1'b0;
        n_vec++; if (bus1.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %b want 1", bus1.in_ready); end
        n_vec++; if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid got %b want 0", bus1.out_valid); end
        bus1.in_valid = 1'b0;
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL bp_scoreboard got empty want 1 entry"); end
        else if (exp_q.pop_front() !== e) begin n_err++; $display("FAIL bp_scoreboard_order"); end
    endtask

    task automatic test_mid_reset;
        int lat;
        bus1.in_data = FIPS_IN; bus1.in_bypass = 1'b0; bus1.in_valid = 1'b1;
        tick;
        bus1.in_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_vec++; if (bus1.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b want 1", bus1.in_ready); end
        n_vec++; if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %b want 0", bus1.out_valid); end
        n_vec++; if (bus1.out_data !== 128'h0) begin n_err++; $display("FAIL midrst_out_data got %h want 0", bus1.out_data); end
        exp_q.push_back(model(BYP_IN, 1'b0));
        bus1.in_data = BYP_IN; bus1.in_bypass = 1'b0; bus1.in_valid = 1'b1;
        tick;
        bus1.in_valid = 1'b0;
        lat = 1;
        while (bus1.out_valid !== 1'b1 && lat < 20) begin tick; lat++; end
        n_vec++; if (bus1.out_data[127:96] !== 32'h2d26314c) begin n_err++; $display("FAIL midrst_col0 got %h want 2d26314c", bus1.out_data[127:96]); end
        n_vec++; if (bus1.out_data !== BYP_INV) begin n_err++; $display("FAIL midrst_data got %h want %h", bus1.out_data, BYP_INV); end
        n_vec++;
        if (exp_q.size() != 1) begin n_err++; $display("FAIL midrst_scoreboard got %0d entries want 1", exp_q.size()); exp_q.delete(); end
        else if (bus1.out_data !== exp_q.pop_front()) begin n_err++; $display("FAIL midrst_model got %h", bus1.out_data); end
        bus1.out_ready = 1'b1;
        tick;
        bus1.out_ready = 1'b0;
    endtask

    task automatic test_param_sweep;
        int lat;
        bus2.in_data = FIPS_IN; bus2.in_bypass = 1'b0; bus2.in_valid = 1'b1;
        tick;
        bus2.in_valid = 1'b0;
        lat = 1;
        while (bus2.out_valid !== 1'b1 && lat < 20) begin tick; lat++; end
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL sweep2_latency got %0d want 3", lat); end
        n_vec++; if (bus2.out_data !== FIPS_OUT) begin n_err++; $display("FAIL sweep2_data got %h want %h", bus2.out_data, FIPS_OUT); end
        bus2.out_ready = 1'b1;
        tick;
        bus2.out_ready = 1'b0;
        n_vec++; if (bus2.in_ready !== 1'b1) begin n_err++; $display("FAIL sweep2_release got %b want 1", bus2.in_ready); end

        bus4.in_data = FIPS_IN; bus4.in_bypass = 1'b0; bus4.in_valid = 1'b1;
        tick;
        bus4.in_valid = 1'b0;
        lat = 1;
        while (bus4.out_valid !== 1'b1 && lat < 20) begin tick; lat++; end
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL sweep4_latency got %0d want 2", lat); end
        n_vec++; if (bus4.out_data !== FIPS_OUT) begin n_err++; $display("FAIL sweep4_data got %h want %h", bus4.out_data, FIPS_OUT); end
        bus4.out_ready = 1'b1;
        tick;
        bus4.out_ready = 1'b0;
        n_vec++; if (bus4.in_ready !== 1'b1) begin n_err++; $display("FAIL sweep4_release got %b want 1", bus4.in_ready); end
    endtask

    task automatic test_random;
        int got;
        int cyc;
        logic [127:0] e;
        got = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [127:0] d;
                    logic         b;
                    int           w;
                    d = {$urandom, $urandom, $urandom, $urandom};
                    b = ($urandom_range(0, 7) == 0);
                    repeat ($urandom_range(0, 2)) tick;
                    bus1.in_data = d; bus1.in_bypass = b; bus1.in_valid = 1'b1;
                    w = 0;
                    while (bus1.in_ready !== 1'b1 && w < 200) begin tick; w++; end
                    if (w >= 200) begin
                        n_vec++; n_err++;
                        $display("FAIL rand_accept_timeout at vector %0d got in_ready=%b want 1", i, bus1.in_ready);
                        break;
                    end
                    exp_q.push_back(model(d, b));
                    tick;
                    bus1.in_valid = 1'b0;
                end
                bus1.in_valid = 1'b0;
            end
            begin
                cyc = 0;
                while (got < 1000 && cyc < 60000) begin
                    bus1.out_ready = 1'($urandom_range(0, 1));
                    if (bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
                        n_vec++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL rand_spurious got %h want no output", bus1.out_data);
                        end else begin
                            e = exp_q.pop_front();
                            if (bus1.out_data !== e) begin
                                n_err++;
                                $display("FAIL rand_data item %0d got %h want %h", got, bus1.out_data, e);
                            end
                        end
                        got++;
                    end
                    tick;
                    cyc++;
                end
                bus1.out_ready = 1'b0;
            end
        join
        n_vec++; if (got != 1000) begin n_err++; $display("FAIL rand_count got %0d want 1000", got); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_leftover got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_bypass();
        test_backpressure();
        test_mid_reset();
        test_param_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
